// File: rtl/imem_arbiter.sv
// Arbiter sharing the single-port, synchronous-read instruction memory between
// the fetch stage and the program loader, with a boot phase and a fetch starvation guard.
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_boot_done,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_gnt,
  output logic              o_f_rvalid,
  output logic [DATA_W-1:0] o_f_rdata,
  input  logic              i_l_req,
  input  logic              i_l_we,
  input  logic [ADDR_W-1:0] i_l_addr,
  input  logic [DATA_W-1:0] i_l_wdata,
  output logic              o_l_gnt,
  output logic              o_l_rvalid,
  output logic [DATA_W-1:0] o_l_rdata,
  output logic              o_m_en,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata,
  output logic              o_running
);

  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic { ST_BOOT, ST_RUN } state_t;
  typedef enum logic [1:0] { OWN_NONE, OWN_FETCH, OWN_LOADER } owner_t;

  state_t           state;
  logic             running_q;
  logic [CNT_W-1:0] starve_cnt;
  owner_t           owner;

  logic f_gnt;
  logic l_gnt;
  logic forced;

  // Grants are combinational so a winning request is served in its own cycle.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    f_gnt  = 1'b0;
    l_gnt  = 1'b0;
    forced = 1'b0;
    if (!i_reset) begin
      if (state == ST_BOOT) begin
        l_gnt = i_l_req;
      end else begin
        forced = i_f_req && (starve_cnt == MAX_CNT);
        f_gnt  = i_f_req && (forced || !i_l_req);
        l_gnt  = i_l_req && !f_gnt;
      end
    end
  end

  always_comb begin
    o_m_en    = f_gnt | l_gnt;
    o_m_we    = 1'b0;
    o_m_addr  = '0;
    o_m_wdata = '0;
    if (f_gnt) begin
      o_m_addr = i_f_addr;
    end else if (l_gnt) begin
      o_m_we    = i_l_we;
      o_m_addr  = i_l_addr;
      o_m_wdata = i_l_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      state      <= ST_BOOT;
      running_q  <= 1'b0;
      starve_cnt <= '0;
      owner      <= OWN_NONE;
    end else begin
      if (f_gnt)                owner <= OWN_FETCH;
      else if (l_gnt && !i_l_we) owner <= OWN_LOADER;
      else                       owner <= OWN_NONE;

      case (state)
        ST_BOOT: begin
          starve_cnt <= '0;
          if (i_boot_done) begin
            state     <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_f_req && !f_gnt)
            starve_cnt <= (starve_cnt == MAX_CNT) ? starve_cnt : starve_cnt + 1'b1;
          else
            starve_cnt <= '0;
        end
        default: begin
          state     <= ST_BOOT;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset gates the registered status so nothing in flight leaks while it is held.
  assign o_f_gnt    = f_gnt;
  assign o_l_gnt    = l_gnt;
  assign o_f_rvalid = (owner == OWN_FETCH) && !i_reset;
  assign o_l_rvalid = (owner == OWN_LOADER) && !i_reset;
  assign o_f_rdata  = i_m_rdata;
  assign o_l_rdata  = i_m_rdata;
  assign o_running  = running_q && !i_reset;

  a_one_grant : assert property (@(posedge i_clk) !(f_gnt && l_gnt));
  a_cnt_range : assert property (@(posedge i_clk) starve_cnt <= MAX_CNT);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a vector table for boot, fetch and loader
// traffic, plus hand sequences for the starvation window and reset mid-read.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_boot_done;
  logic        i_f_req;
  logic [31:0] i_f_addr;
  logic        o_f_gnt, o_f_rvalid;
  logic [31:0] o_f_rdata;
  logic        i_l_req, i_l_we;
  logic [31:0] i_l_addr, i_l_wdata;
  logic        o_l_gnt, o_l_rvalid;
  logic [31:0] o_l_rdata;
  logic        o_m_en, o_m_we;
  logic [31:0] o_m_addr, o_m_wdata;
  logic [31:0] i_m_rdata;
  logic        o_running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_boot_done(i_boot_done),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr), .o_f_gnt(o_f_gnt),
    .o_f_rvalid(o_f_rvalid), .o_f_rdata(o_f_rdata),
    .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
    .o_l_gnt(o_l_gnt), .o_l_rvalid(o_l_rvalid), .o_l_rdata(o_l_rdata),
    .o_m_en(o_m_en), .o_m_we(o_m_we), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .i_m_rdata(i_m_rdata), .o_running(o_running)
  );

  // Synchronous-read memory model: 16 words, preloaded with A000_0000 + index.
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    i_m_rdata = '0;
  end
  always @(posedge clk) begin
    if (o_m_en && o_m_we)  mem[o_m_addr[5:2]] <= o_m_wdata;
    if (o_m_en && !o_m_we) i_m_rdata <= mem[o_m_addr[5:2]];
  end

  typedef struct {
    logic        boot_done, f_req;
    logic [31:0] f_addr;
    logic        l_req, l_we;
    logic [31:0] l_addr, l_wdata;
    logic        e_f_gnt, e_l_gnt, e_m_en, e_m_we;
    logic [31:0] e_m_addr;
    logic        e_f_rv, e_l_rv, e_run;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic bd, fr, input logic [31:0] fa,
    input logic lr, lwe, input logic [31:0] la, lwd,
    input logic fg, lg, men, mwe, input logic [31:0] maddr,
    input logic frv, lrv, run, input logic [31:0] rd);
    vec_t v;
    v.boot_done = bd; v.f_req = fr; v.f_addr = fa;
    v.l_req = lr; v.l_we = lwe; v.l_addr = la; v.l_wdata = lwd;
    v.e_f_gnt = fg; v.e_l_gnt = lg; v.e_m_en = men; v.e_m_we = mwe; v.e_m_addr = maddr;
    v.e_f_rv = frv; v.e_l_rv = lrv; v.e_run = run; v.e_rdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    i_boot_done = 1'b0; i_f_req = 1'b0; i_f_addr = '0;
    i_l_req = 1'b0; i_l_we = 1'b0; i_l_addr = '0; i_l_wdata = '0;
  endtask

  vec_t vecs [$];

  initial begin
    i_reset = 1'b1;
    drive_idle();

    // BOOT: fetch held high for 10 cycles without boot_done is never served.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,1,32'h0, 0,0,0,0, 0,0,0,0,32'h0, 0,0,0,0));
    // Loader write 0x13 -> 0x4, then read 0x4 with boot_done in the same cycle.
    vecs.push_back(mk(0,1,32'h0, 1,1,32'h4,32'h13, 0,1,1,1,32'h4, 0,0,0,0));
    vecs.push_back(mk(1,0,32'h0, 1,0,32'h4,32'h0,  0,1,1,0,32'h4, 0,0,0,0));
    vecs.push_back(mk(0,0,32'h0, 0,0,0,0,          0,0,0,0,32'h0, 0,1,1,32'h13));
    // RUN: fetch-only stream 0x0, 0x4, 0x8 with one-cycle read returns.
    vecs.push_back(mk(0,1,32'h0, 0,0,0,0, 1,0,1,0,32'h0, 0,0,1,0));
    vecs.push_back(mk(0,1,32'h4, 0,0,0,0, 1,0,1,0,32'h4, 1,0,1,32'hA000_0000));
    vecs.push_back(mk(0,1,32'h8, 0,0,0,0, 1,0,1,0,32'h8, 1,0,1,32'h13));
    vecs.push_back(mk(0,0,32'h0, 0,0,0,0, 0,0,0,0,32'h0, 1,0,1,32'hA000_0002));
    // Loader write collides with fetch at starve_cnt 0, then fetch goes next.
    vecs.push_back(mk(0,1,32'h10, 1,1,32'hC,32'hDEAD, 0,1,1,1,32'hC,  0,0,1,0));
    vecs.push_back(mk(0,1,32'h10, 0,0,0,0,            1,0,1,0,32'h10, 0,0,1,0));
    vecs.push_back(mk(0,0,32'h0,  0,0,0,0,            0,0,0,0,32'h0,  1,0,1,32'hA000_0004));

    // Reset held with a loader request: no grant, no memory access.
    i_l_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_l_gnt", 32'(o_l_gnt), 0);
      check("rst_m_en", 32'(o_m_en), 0);
      check("rst_running", 32'(o_running), 0);
      check("rst_rvalid", 32'({o_f_rvalid, o_l_rvalid}), 0);
    end
    @(posedge clk);
    #1 i_reset = 1'b0;
    drive_idle();
    @(negedge clk);
    check("post_rst_starve", 32'(dut.starve_cnt), 0);
    check("post_rst_rvalid", 32'({o_f_rvalid, o_l_rvalid}), 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      i_boot_done = vecs[i].boot_done; i_f_req = vecs[i].f_req; i_f_addr = vecs[i].f_addr;
      i_l_req = vecs[i].l_req; i_l_we = vecs[i].l_we;
      i_l_addr = vecs[i].l_addr; i_l_wdata = vecs[i].l_wdata;
      @(negedge clk);
      check($sformatf("v%0d_f_gnt", i),   32'(o_f_gnt),    32'(vecs[i].e_f_gnt));
      check($sformatf("v%0d_l_gnt", i),   32'(o_l_gnt),    32'(vecs[i].e_l_gnt));
      check($sformatf("v%0d_m_en", i),    32'(o_m_en),     32'(vecs[i].e_m_en));
      check($sformatf("v%0d_m_we", i),    32'(o_m_we),     32'(vecs[i].e_m_we));
      check($sformatf("v%0d_m_addr", i),  o_m_addr,        vecs[i].e_m_addr);
      check($sformatf("v%0d_f_rv", i),    32'(o_f_rvalid), 32'(vecs[i].e_f_rv));
      check($sformatf("v%0d_l_rv", i),    32'(o_l_rvalid), 32'(vecs[i].e_l_rv));
      check($sformatf("v%0d_running", i), 32'(o_running),  32'(vecs[i].e_run));
      if (vecs[i].e_m_we) check($sformatf("v%0d_m_wdata", i), o_m_wdata, vecs[i].l_wdata);
      if (vecs[i].e_f_rv) check($sformatf("v%0d_f_rdata", i), o_f_rdata, vecs[i].e_rdata);
      if (vecs[i].e_l_rv) check($sformatf("v%0d_l_rdata", i), o_l_rdata, vecs[i].e_rdata);
    end

    // Both requesters held for 15 cycles: pattern L,L,L,L,F three times.
    begin
      logic prev_f, prev_l, exp_f;
      prev_f = 1'b0; prev_l = 1'b0;
      for (int k = 0; k < 15; k++) begin
        @(posedge clk);
        #1;
        i_f_req = 1'b1; i_f_addr = 32'h14;
        i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 32'h20;
        exp_f = (k % 5 == 4);
        @(negedge clk);
        check($sformatf("st%0d_f_gnt", k),  32'(o_f_gnt), 32'(exp_f));
        check($sformatf("st%0d_l_gnt", k),  32'(o_l_gnt), 32'(!exp_f));
        check($sformatf("st%0d_m_addr", k), o_m_addr, exp_f ? 32'h14 : 32'h20);
        check($sformatf("st%0d_f_rv", k),   32'(o_f_rvalid), 32'(prev_f));
        check($sformatf("st%0d_l_rv", k),   32'(o_l_rvalid), 32'(prev_l));
        if (prev_l) check($sformatf("st%0d_l_rdata", k), o_l_rdata, 32'hA000_0008);
        if (prev_f) check($sformatf("st%0d_f_rdata", k), o_f_rdata, 32'hA000_0005);
        check($sformatf("st%0d_cnt_le_max", k), 32'(dut.starve_cnt <= 4), 1);
        prev_f = exp_f; prev_l = !exp_f;
      end
    end

    // Reset rises while fetch requests (and a fetch return is due): all suppressed.
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    i_l_req = 1'b0; i_f_req = 1'b1; i_f_addr = 32'h0;
    @(negedge clk);
    check("rr_f_gnt", 32'(o_f_gnt), 0);
    check("rr_m_en", 32'(o_m_en), 0);
    check("rr_f_rv_during", 32'(o_f_rvalid), 0);
    check("rr_running_during", 32'(o_running), 0);
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("rr_f_rv_after", 32'(o_f_rvalid), 0);
    check("rr_running_after", 32'(o_running), 0);
    check("rr_starve_after", 32'(dut.starve_cnt), 0);
    check("rr_boot_no_fetch", 32'(o_f_gnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port, synchronous-read instruction memory between the fetch stage and the program loader/debug port. After reset, a boot-phase state machine grants the memory only to the loader. Once the loader signals completion, the block arbitrates both requesters every cycle. The loader has default priority, and a starvation counter guarantees fetch forward progress. The block sits between the IF-stage PC/fetch logic and the imem macro.

## Interface

Parameters:
- ADDR_W, 32, address width of both requesters and the memory
- DATA_W, 32, instruction/data word width
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch gets forced priority (legal range ≥ 1)

Ports:
- i_clk  in  1  clock; one clock domain, all logic rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_boot_done  in  1  loader finished; single-cycle pulse or level
- i_f_req  in  1  fetch read request
- i_f_addr  in  ADDR_W  fetch address (PC)
- o_f_gnt  out  1  fetch granted this cycle
- o_f_rvalid  out  1  fetch read data valid
- o_f_rdata  out  DATA_W  fetch read data (instruction)
- i_l_req  in  1  loader request
- i_l_we  in  1  loader write enable (1 = write, 0 = read)
- i_l_addr  in  ADDR_W  loader address
- i_l_wdata  in  DATA_W  loader write data
- o_l_gnt  out  1  loader granted this cycle
- o_l_rvalid  out  1  loader read data valid
- o_l_rdata  out  DATA_W  loader read data
- o_m_en  out  1  memory access enable
- o_m_we  out  1  memory write enable
- o_m_addr  out  ADDR_W  memory address
- o_m_wdata  out  DATA_W  memory write data
- i_m_rdata  in  DATA_W  memory read data; valid one cycle after a read access
- o_running  out  1  high in RUN state

## Operation

- State machine with two states, BOOT and RUN. Reset enters BOOT.
- BOOT:
  - Only the loader may be granted: o_l_gnt = i_l_req; o_f_gnt = 0.
  - i_boot_done = 1 moves the FSM to RUN on the next edge.
  - A loader request in the same cycle as i_boot_done is still granted.
- RUN:
  - i_boot_done is ignored. RUN is left only by reset.
  - At most one grant per cycle. The grant is combinational from the requests and registered state.
  - Default priority is loader over fetch.
  - Forced fetch: when starve_cnt == MAX_WAIT and i_f_req = 1, fetch wins and the loader is denied that cycle.
- Starvation counter, starve_cnt:
  - Width clog2(MAX_WAIT+1).
  - In RUN, increments when i_f_req = 1 and fetch is not granted. Saturates at MAX_WAIT.
  - Clears to 0 when fetch is granted or i_f_req = 0.
  - Held at 0 in BOOT.
- Memory command: o_m_en = o_f_gnt | o_l_gnt.
  - Fetch grant: o_m_addr = i_f_addr, o_m_we = 0.
  - Loader grant: o_m_addr = i_l_addr, o_m_we = i_l_we, o_m_wdata = i_l_wdata.
  - No grant: o_m_addr, o_m_wdata = 0 and o_m_we = 0.
- Read return:
  - A registered owner tag records which requester issued the read.
  - o_f_rvalid is asserted on the cycle after a fetch grant.
  - o_l_rvalid is asserted on the cycle after a loader read grant (i_l_we = 0).
  - Loader writes produce no rvalid.
  - o_f_rdata and o_l_rdata both equal i_m_rdata. Consumers qualify the data with their own rvalid.
- Requesters must hold req/addr/wdata stable until granted. Deasserting a request before it is granted is permitted.

## Timing

- Reset values, while i_reset is high and on the first cycle after it:
  - State BOOT, starve_cnt = 0, o_running = 0.
  - o_f_rvalid = 0, o_l_rvalid = 0.
  - While i_reset is high, all grants and o_m_en are forced to 0.
- Grant latency is 0 cycles: a request is granted in the same cycle when it wins arbitration.
- Read latency is 1 cycle: rvalid and rdata appear on the cycle after the grant.
- Back-to-back grants to the same requester on consecutive cycles are supported. Each returns its own rvalid pulse at a 1-cycle offset.
- BOOT to RUN: i_boot_done sampled high at edge N gives o_running = 1 from cycle N+1. Fetch can first be granted in cycle N+1.
- Forced-fetch window:
  - With continuous loader and fetch requests in RUN, fetch is denied exactly MAX_WAIT cycles, then granted for one cycle.
  - The counter then clears and the pattern repeats.
- Reset mid-read: an in-flight rvalid, i.e. grant in the cycle where i_reset rises, is suppressed; no rvalid pulse follows.
- Simultaneous requests with starve_cnt < MAX_WAIT: the loader is granted and starve_cnt increments.

## Test plan

- Reset, then i_f_req = 1 with addr 0x0 for 10 cycles without i_boot_done -> o_f_gnt stays 0, o_m_en = 0, o_running = 0.
- BOOT: loader writes 0x00000013 to 0x4 and then reads 0x4; pulse i_boot_done in the read cycle -> write with o_m_we = 1; read granted; o_l_rvalid = 1 next cycle with data 0x00000013; o_running = 1 that same cycle.
- RUN: only fetch requesting, addresses 0x0, 0x4, 0x8 on consecutive cycles -> o_f_gnt = 1 each cycle; o_f_rvalid = 1 on the three following cycles with the matching i_m_rdata.
- RUN with MAX_WAIT = 4: both requesters held high for 15 cycles -> grant pattern L,L,L,L,F repeated 3 times; starve_cnt never exceeds 4.
- Fetch granted in cycle N; i_reset asserted in cycle N -> o_f_rvalid = 0 in cycle N+1; state BOOT, starve_cnt = 0.
- RUN: loader write and fetch request arrive together with starve_cnt = 0 -> loader granted with o_m_we = 1 and no rvalid; fetch granted next cycle once the loader drops its request.
